// File: rtl/key_cmd_ctrl.sv
// Keypad command controller: debounces the scanner's key level/code, maps maze keys
// to commands, auto-repeats held direction keys and queues commands in a FWFT FIFO.
module key_cmd_ctrl #(
   parameter int DEBOUNCE_CYC     = 1_000_000,
   parameter int REPEAT_DELAY_CYC = 25_000_000,
   parameter int REPEAT_RATE_CYC  = 5_000_000,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          key_down,
   input  logic [3:0]                    key_value,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [2:0]                    cmd_code,
   output logic                          cmd_repeat,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    drop_count,
   output logic [2:0]                    dbg_state
);

   // Handshake: an entry moves to the engine on any clock edge where cmd_valid and
   // cmd_ready are both high; the head entry is held stable until that happens.

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
   localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_HOLD     = 3'd2,
      S_REPEAT   = 3'd3,
      S_RELEASE  = 3'd4
   } state_e;

   // Returns {mapped, command code}
   function automatic logic [3:0] map_key(input logic [3:0] k);
      case (k)
         4'd1:    map_key = 4'b1_000;
         4'd9:    map_key = 4'b1_001;
         4'd4:    map_key = 4'b1_010;
         4'd6:    map_key = 4'b1_011;
         4'd5:    map_key = 4'b1_100;
         4'd15:   map_key = 4'b1_101;
         default: map_key = 4'b0_000;
      endcase
   endfunction

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         cand_q, cand_d;
   logic [3:0]         cand_map;
   logic               mapped, rpt_ok, released;
   logic               push, push_rep;

   logic [3:0]         mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        count_q, count_d;
   logic [7:0]         drop_q;
   logic               pop, full, push_ok, drop;

   assign cand_map = map_key(cand_q);
   assign mapped   = cand_map[3];
   assign rpt_ok   = mapped & ~cand_map[2];
   assign released = ~key_down | (key_value != cand_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      cand_d   = cand_q;
      push     = 1'b0;
      push_rep = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (key_down) begin
               cand_d  = key_value;
               state_d = S_DEBOUNCE;
            end
         end
         S_DEBOUNCE: begin
            if (!key_down) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (key_value != cand_q) begin
               cand_d = key_value;
               cnt_d  = '0;
            end else if (cnt_q == DEB_LAST) begin
               push    = mapped;
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            if (released) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == DLY_LAST) begin
               push     = rpt_ok;
               push_rep = 1'b1;
               state_d  = S_REPEAT;
               cnt_d    = '0;
            end
         end
         S_REPEAT: begin
            if (released) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == RPT_LAST) begin
               push     = rpt_ok;
               push_rep = 1'b1;
               cnt_d    = '0;
            end
         end
         S_RELEASE: begin
            // Any re-press restarts the release window
            if (key_down) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign cmd_valid = (count_q != '0);
   assign pop       = cmd_valid & cmd_ready;
   assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot a full-FIFO push needs
   assign push_ok   = push & (~full | pop);
   assign drop      = push & full & ~pop;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cand_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         count_q <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {push_rep, cand_map[2:0]};
   end

   assign cmd_code   = cmd_valid ? mem_q[rd_ptr_q][2:0] : 3'd0;
   assign cmd_repeat = cmd_valid ? mem_q[rd_ptr_q][3]   : 1'b0;
   assign fifo_level = count_q;
   assign drop_count = drop_q;
   assign dbg_state  = state_q;

endmodule
